// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B3 encodings, arbiter state type and watchdog sizing helper
// for the peripheral bus slice.
package peripheral_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  localparam logic WB_READ  = 1'b0;
  localparam logic WB_WRITE = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // Stall counter width: wide enough for the limit, clamped to 8..16 bits.
  function automatic int wd_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// Round-robin pointer with one-hot priority select. The winner is computed from
// the pointer value that will be in effect after this edge, so a release can
// hand over to the next requester without an idle cycle.
module peripheral_arbiter_rr
  import peripheral_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   advance,
  input  logic [NUM_MASTERS-1:0] release_grant,
  output logic [NUM_MASTERS-1:0] winner,
  output logic                   any_req
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PW-1:0] ptr_reg, ptr_next, rel_idx, idx;
  logic          found;

  always_comb begin
    rel_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (release_grant[i]) rel_idx = PW'(i);
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance) ptr_next = (rel_idx == PW'(NUM_MASTERS - 1)) ? '0 : rel_idx + PW'(1);
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = PW'((int'(ptr_next) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_req = |req;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone B3 arbiter: one slave shared by NUM_MASTERS masters, grant held
// for the whole wb_cyc. Optional stall watchdog: define PERIPHERAL_ARBITER_WB_WATCHDOG_EN.
module peripheral_arbiter_wb
  import peripheral_wb_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  arb_state_e             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next, winner;
  logic                   any_req, granted_cyc, advance;
  logic                   wd_fire, wd_hold;

  logic [AW-1:0]   adr_m [NUM_MASTERS];
  logic [DW-1:0]   dat_m [NUM_MASTERS];
  logic [DW/8-1:0] sel_m [NUM_MASTERS];
  logic [2:0]      cti_m [NUM_MASTERS];
  logic [1:0]      bte_m [NUM_MASTERS];
  logic [AW-1:0]   mux_adr;
  logic [DW-1:0]   mux_dat;
  logic [DW/8-1:0] mux_sel;
  logic [2:0]      mux_cti;
  logic [1:0]      mux_bte;
  logic            mux_stb;

  assign granted_cyc = |(wbm_cyc_i & grant_reg);
  assign advance     = (state_reg == GRANTED) && !granted_cyc;

  peripheral_arbiter_rr #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .req          (wbm_cyc_i),
    .advance      (advance),
    .release_grant(grant_reg),
    .winner       (winner),
    .any_req      (any_req)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = GRANTED;
          grant_next = winner;
        end
      end
      GRANTED: begin
        // Only the owner dropping cyc ends a tenure; the released master's cyc is
        // already low, so the winner here is always a different master.
        if (!granted_cyc) begin
          if (any_req) begin
            grant_next = winner;
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  // Zero every non-granted master's request so the slave bus is a plain OR.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
      assign adr_m[gi] = grant_reg[gi] ? wbm_adr_i[gi*AW +: AW]     : '0;
      assign dat_m[gi] = grant_reg[gi] ? wbm_dat_i[gi*DW +: DW]     : '0;
      assign sel_m[gi] = grant_reg[gi] ? wbm_sel_i[gi*DW/8 +: DW/8] : '0;
      assign cti_m[gi] = grant_reg[gi] ? wbm_cti_i[gi*3 +: 3]       : '0;
      assign bte_m[gi] = grant_reg[gi] ? wbm_bte_i[gi*2 +: 2]       : '0;
    end
  endgenerate

  always_comb begin
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    mux_cti = '0;
    mux_bte = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mux_adr |= adr_m[i];
      mux_dat |= dat_m[i];
      mux_sel |= sel_m[i];
      mux_cti |= cti_m[i];
      mux_bte |= bte_m[i];
    end
  end

  assign mux_stb   = |(wbm_stb_i & grant_reg);
  assign wbs_adr_o = mux_adr;
  assign wbs_dat_o = mux_dat;
  assign wbs_sel_o = mux_sel;
  assign wbs_cti_o = mux_cti;
  assign wbs_bte_o = mux_bte;
  assign wbs_we_o  = |(wbm_we_i & grant_reg);
  assign wbs_cyc_o = granted_cyc;
  assign wbs_stb_o = mux_stb & ~wd_hold;

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = grant_reg & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = grant_reg & {NUM_MASTERS{wbs_err_i | wd_fire}};
  assign wbm_rty_o = grant_reg & {NUM_MASTERS{wbs_rty_i}};
  assign grant_o   = grant_reg;

`ifdef PERIPHERAL_ARBITER_WB_WATCHDOG_EN
  localparam int WD_W = wd_cnt_width(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_hold_reg, slv_resp;

  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wd_fire  = (state_reg == GRANTED) && !wd_hold_reg && !slv_resp &&
                    (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES));
  assign wd_hold  = wd_hold_reg;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wd_cnt_reg  <= '0;
      wd_hold_reg <= 1'b0;
    end else if (!granted_cyc || (grant_next != grant_reg)) begin
      wd_cnt_reg  <= '0;
      wd_hold_reg <= 1'b0;
    end else if (wd_fire) begin
      wd_cnt_reg  <= '0;
      wd_hold_reg <= 1'b1;
    end else if (slv_resp) begin
      wd_cnt_reg <= '0;
    end else if (mux_stb && !wd_hold_reg) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
  assign wd_hold = 1'b0;
`endif

endmodule
